// File: rtl/boot_pkg.sv
// Shared types and default sizing for the boot segment loader.
// No logic here; latency not applicable.
// No backpressure; types only.
package boot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } boot_state_t;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_LEN_W  = 32;
  localparam int DEF_DEPTH  = 4;

  // Width of one packed descriptor {addr, len}.
  function automatic int desc_w(input int addr_w, input int len_w);
    return addr_w + len_w;
  endfunction

endpackage

// File: rtl/boot_desc_fifo.sv
// Circular descriptor queue with wrapping read/write pointers and sticky overflow flag.
// Push visible in count one cycle later; head is read combinationally.
// A push while full is dropped (sets ovf) unless a pop happens in the same cycle.
module boot_desc_fifo
  import boot_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int W     = DEF_ADDR_W + DEF_LEN_W
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];
  assign ovf   = ovf_q;

  // Next-state: a full queue still accepts a push when the head leaves in the same cycle.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !push_ok) begin
      ovf_d = 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (clr) begin
      mem_d    = mem_q;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end
  end

  // State registers; storage contents are don't-care after a flush.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: rtl/boot_segment_loader.sv
// Drains queued {addr,len} descriptors into per-segment beat streams.
// First beat_valid two cycles after start (IDLE->LOAD->STREAM); zero-length segments are skipped.
// beat_addr/beat_idx hold while beat_valid && !beat_ready; pushes accepted in every state.
module boot_segment_loader
  import boot_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   clr,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic [LEN_W-1:0]       len_i,
  input  logic                   start,
  input  logic                   beat_ready,
  output logic                   beat_valid,
  output logic [ADDR_W-1:0]      beat_addr,
  output logic [LEN_W-1:0]       beat_idx,
  output logic                   beat_last,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   ovf
);

  localparam int DW    = desc_w(ADDR_W, LEN_W);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  boot_state_t       state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  cur_len_q, cur_len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic              vld_q, vld_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              pop;
  logic [DW-1:0]     head;
  logic [ADDR_W-1:0] head_addr;
  logic [LEN_W-1:0]  head_len;

  assign head_addr = head[DW-1:LEN_W];
  assign head_len  = head[LEN_W-1:0];

  boot_desc_fifo #(
    .DEPTH(DEPTH),
    .W    (DW)
  ) u_fifo (
    .clk  (clk),
    .clr_n(clr_n),
    .clr  (clr),
    .push (wr_en),
    .pop  (pop),
    .din  ({addr_i, len_i}),
    .dout (head),
    .count(count),
    .full (full),
    .empty(empty),
    .ovf  (ovf)
  );

  assign beat_valid = vld_q;
  assign beat_addr  = cur_addr_q;
  assign beat_idx   = idx_q;
  assign beat_last  = last_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

  // Sequencer next-state: beat_last is precomputed so it is registered alongside beat_idx.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    cur_len_d  = cur_len_q;
    idx_d      = idx_q;
    vld_d      = vld_q;
    last_d     = last_q;
    err_d      = 1'b0;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (empty) err_d   = 1'b1;
          else       state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        pop        = 1'b1;
        cur_addr_d = head_addr;
        cur_len_d  = head_len;
        idx_d      = '0;
        if (head_len == '0) begin
          // Head leaves this cycle, so more work remains only if something is behind it.
          state_d = (count > CNT_W'(1)) ? ST_LOAD : ST_DONE;
        end else begin
          state_d = ST_STREAM;
          vld_d   = 1'b1;
          last_d  = (head_len == LEN_W'(1));
        end
      end
      ST_STREAM: begin
        if (vld_q && beat_ready) begin
          if (last_q) begin
            vld_d   = 1'b0;
            last_d  = 1'b0;
            state_d = empty ? ST_DONE : ST_LOAD;
          end else begin
            // idx_q <= cur_len-2 here, so idx+2 never wraps.
            idx_d  = idx_q + LEN_W'(1);
            last_d = ((idx_q + LEN_W'(2)) == cur_len_q);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (clr) begin
      state_d    = ST_IDLE;
      cur_addr_d = '0;
      cur_len_d  = '0;
      idx_d      = '0;
      vld_d      = 1'b0;
      last_d     = 1'b0;
      err_d      = 1'b0;
      pop        = 1'b0;
    end
    done_d = (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= ST_IDLE;
      cur_addr_q <= '0;
      cur_len_q  <= '0;
      idx_q      <= '0;
      vld_q      <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      cur_len_q  <= cur_len_d;
      idx_q      <= idx_d;
      vld_q      <= vld_d;
      last_q     <= last_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_boot_segment_loader.sv
// Directed vector table plus hand-written sequences for the boot segment loader.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
// Default parameters: ADDR_W=8, LEN_W=32, DEPTH=4.
module tb_boot_segment_loader;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        clr;
  logic        wr_en;
  logic [7:0]  addr_i;
  logic [31:0] len_i;
  logic        start;
  logic        beat_ready;
  logic        beat_valid;
  logic [7:0]  beat_addr;
  logic [31:0] beat_idx;
  logic        beat_last;
  logic [2:0]  count;
  logic        full, empty, busy, done, err, ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  boot_segment_loader dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .clr       (clr),
    .wr_en     (wr_en),
    .addr_i    (addr_i),
    .len_i     (len_i),
    .start     (start),
    .beat_ready(beat_ready),
    .beat_valid(beat_valid),
    .beat_addr (beat_addr),
    .beat_idx  (beat_idx),
    .beat_last (beat_last),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .ovf       (ovf)
  );

  typedef struct {
    logic        clr, wr, st, rdy;
    logic [7:0]  a;
    logic [31:0] l;
    logic        vld, last, busy, done, ovf, err;
    logic [7:0]  ea;
    logic [31:0] ei;
    logic [2:0]  cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic c, input logic w, input logic [7:0] a, input logic [31:0] l,
                             input logic s, input logic r, input logic vl, input logic [7:0] ea,
                             input logic [31:0] ei, input logic la, input logic [2:0] cn,
                             input logic bs, input logic dn, input logic ov, input logic er);
    vec_t t;
    t.clr = c; t.wr = w; t.a = a; t.l = l; t.st = s; t.rdy = r;
    t.vld = vl; t.ea = ea; t.ei = ei; t.last = la; t.cnt = cn;
    t.busy = bs; t.done = dn; t.ovf = ov; t.err = er;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr = 1'b0; wr_en = 1'b0; addr_i = '0; len_i = '0; start = 1'b0; beat_ready = 1'b0;
  endtask

  task automatic push(input logic [7:0] a, input logic [31:0] l);
    wr_en = 1'b1; addr_i = a; len_i = l;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, beat_valid, 1'b0);
    chk({tag, "_addr"},  beat_addr, 8'd0);
    chk({tag, "_idx"},   beat_idx, 32'd0);
    chk({tag, "_last"},  beat_last, 1'b0);
    chk({tag, "_count"}, count, 3'd0);
    chk({tag, "_full"},  full, 1'b0);
    chk({tag, "_empty"}, empty, 1'b1);
    chk({tag, "_busy"},  busy, 1'b0);
    chk({tag, "_done"},  done, 1'b0);
    chk({tag, "_err"},   err, 1'b0);
    chk({tag, "_ovf"},   ovf, 1'b0);
  endtask

  initial begin
    int n;
    int hs;
    logic pv, pr;
    logic [7:0] pa;
    logic [31:0] pi;
    logic seen_done;

    idle_inputs();
    clr_n = 1'b0;
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    clr_n = 1'b1;
    tick();
    chk_reset_outputs("post_reset");

    // Multi-segment with a zero-length skip, then start on an empty queue.
    tbl.push_back(v(1,0,8'd0,32'd0,0,0, 0,8'd0,32'd0,0,3'd0, 0,0,0,0));
    tbl.push_back(v(0,1,8'd1,32'd2,0,0, 0,8'd0,32'd0,0,3'd1, 0,0,0,0));
    tbl.push_back(v(0,1,8'd2,32'd0,0,0, 0,8'd0,32'd0,0,3'd2, 0,0,0,0));
    tbl.push_back(v(0,1,8'd5,32'd1,0,0, 0,8'd0,32'd0,0,3'd3, 0,0,0,0));
    tbl.push_back(v(0,0,8'd0,32'd0,1,1, 0,8'd0,32'd0,0,3'd3, 1,0,0,0));
    tbl.push_back(v(0,0,8'd0,32'd0,0,1, 1,8'd1,32'd0,0,3'd2, 1,0,0,0));
    tbl.push_back(v(0,0,8'd0,32'd0,0,1, 1,8'd1,32'd1,1,3'd2, 1,0,0,0));
    tbl.push_back(v(0,0,8'd0,32'd0,0,1, 0,8'd0,32'd0,0,3'd2, 1,0,0,0));
    tbl.push_back(v(0,0,8'd0,32'd0,0,1, 0,8'd0,32'd0,0,3'd1, 1,0,0,0));
    tbl.push_back(v(0,0,8'd0,32'd0,0,1, 1,8'd5,32'd0,1,3'd0, 1,0,0,0));
    tbl.push_back(v(0,0,8'd0,32'd0,0,1, 0,8'd0,32'd0,0,3'd0, 1,1,0,0));
    tbl.push_back(v(0,0,8'd0,32'd0,0,0, 0,8'd0,32'd0,0,3'd0, 0,0,0,0));
    tbl.push_back(v(0,0,8'd0,32'd0,1,0, 0,8'd0,32'd0,0,3'd0, 0,0,0,1));
    tbl.push_back(v(0,0,8'd0,32'd0,0,0, 0,8'd0,32'd0,0,3'd0, 0,0,0,0));
    // Overflow: fifth push dropped, then clr with a coincident push.
    tbl.push_back(v(1,0,8'd0,32'd0,0,0, 0,8'd0,32'd0,0,3'd0, 0,0,0,0));
    tbl.push_back(v(0,1,8'd1,32'd1,0,0, 0,8'd0,32'd0,0,3'd1, 0,0,0,0));
    tbl.push_back(v(0,1,8'd2,32'd1,0,0, 0,8'd0,32'd0,0,3'd2, 0,0,0,0));
    tbl.push_back(v(0,1,8'd3,32'd1,0,0, 0,8'd0,32'd0,0,3'd3, 0,0,0,0));
    tbl.push_back(v(0,1,8'd4,32'd1,0,0, 0,8'd0,32'd0,0,3'd4, 0,0,0,0));
    tbl.push_back(v(0,1,8'd5,32'd1,0,0, 0,8'd0,32'd0,0,3'd4, 0,0,1,0));
    tbl.push_back(v(0,0,8'd0,32'd0,0,0, 0,8'd0,32'd0,0,3'd4, 0,0,1,0));
    tbl.push_back(v(1,1,8'd6,32'd1,0,0, 0,8'd0,32'd0,0,3'd0, 0,0,0,0));
    // Full queue while streaming; push coincident with the LOAD pop.
    tbl.push_back(v(0,1,8'd10,32'd1,0,0, 0,8'd0,32'd0,0,3'd1, 0,0,0,0));
    tbl.push_back(v(0,1,8'd11,32'd2,1,0, 0,8'd0,32'd0,0,3'd2, 1,0,0,0));
    tbl.push_back(v(0,1,8'd12,32'd1,0,0, 1,8'd10,32'd0,1,3'd2, 1,0,0,0));
    tbl.push_back(v(0,1,8'd13,32'd1,0,0, 1,8'd10,32'd0,1,3'd3, 1,0,0,0));
    tbl.push_back(v(0,1,8'd14,32'd1,0,0, 1,8'd10,32'd0,1,3'd4, 1,0,0,0));
    tbl.push_back(v(0,0,8'd0,32'd0,0,1, 0,8'd0,32'd0,0,3'd4, 1,0,0,0));
    tbl.push_back(v(0,1,8'd15,32'd1,0,1, 1,8'd11,32'd0,0,3'd4, 1,0,0,0));
    tbl.push_back(v(0,0,8'd0,32'd0,0,1, 1,8'd11,32'd1,1,3'd4, 1,0,0,0));
    tbl.push_back(v(0,0,8'd0,32'd0,0,1, 0,8'd0,32'd0,0,3'd4, 1,0,0,0));
    tbl.push_back(v(0,0,8'd0,32'd0,0,1, 1,8'd12,32'd0,1,3'd3, 1,0,0,0));
    tbl.push_back(v(1,0,8'd0,32'd0,0,1, 0,8'd0,32'd0,0,3'd0, 0,0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      clr = tbl[i].clr; wr_en = tbl[i].wr; addr_i = tbl[i].a; len_i = tbl[i].l;
      start = tbl[i].st; beat_ready = tbl[i].rdy;
      tick();
      chk($sformatf("vec%0d_valid", i), beat_valid, tbl[i].vld);
      chk($sformatf("vec%0d_last", i),  beat_last,  tbl[i].last);
      chk($sformatf("vec%0d_count", i), count,      tbl[i].cnt);
      chk($sformatf("vec%0d_full", i),  full,       tbl[i].cnt == 3'd4);
      chk($sformatf("vec%0d_empty", i), empty,      tbl[i].cnt == 3'd0);
      chk($sformatf("vec%0d_busy", i),  busy,       tbl[i].busy);
      chk($sformatf("vec%0d_done", i),  done,       tbl[i].done);
      chk($sformatf("vec%0d_ovf", i),   ovf,        tbl[i].ovf);
      chk($sformatf("vec%0d_err", i),   err,        tbl[i].err);
      if (tbl[i].vld) begin
        chk($sformatf("vec%0d_addr", i), beat_addr, tbl[i].ea);
        chk($sformatf("vec%0d_idx", i),  beat_idx,  tbl[i].ei);
      end
    end
    idle_inputs();

    // Long segment: 400 beats, first beat two edges after the start edge.
    push(8'd3, 32'd400);
    start = 1'b1; beat_ready = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!beat_valid && n < 10) begin
      tick();
      n++;
    end
    chk("long_first_beat_latency", n, 2);
    for (int i = 0; i < 400; i++) begin
      chk("long_valid", beat_valid, 1'b1);
      chk("long_addr",  beat_addr, 8'd3);
      chk("long_idx",   beat_idx, i);
      chk("long_last",  beat_last, i == 399);
      tick();
    end
    chk("long_done_pulse", done, 1'b1);
    chk("long_valid_off", beat_valid, 1'b0);
    tick();
    chk("long_done_clear", done, 1'b0);
    chk("long_busy_clear", busy, 1'b0);
    beat_ready = 1'b0;

    // Random stalls on a length-5 segment.
    push(8'd7, 32'd5);
    start = 1'b1;
    tick();
    start = 1'b0;
    hs = 0;
    seen_done = 1'b0;
    for (int c = 0; c < 300 && !seen_done; c++) begin
      beat_ready = 1'($urandom_range(0, 1));
      pv = beat_valid; pr = beat_ready; pa = beat_addr; pi = beat_idx;
      tick();
      if (pv && pr) begin
        chk("stall_hs_addr", pa, 8'd7);
        chk("stall_hs_idx", pi, hs);
        hs++;
      end else if (pv) begin
        chk("stall_hold_addr", beat_addr, pa);
        chk("stall_hold_idx", beat_idx, pi);
      end
      if (done) seen_done = 1'b1;
    end
    chk("stall_done_seen", seen_done, 1'b1);
    chk("stall_handshakes", hs, 5);
    beat_ready = 1'b0;
    tick();

    // Asynchronous reset asserted mid-stream.
    push(8'd9, 32'd10);
    start = 1'b1; beat_ready = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("midrst_streaming", beat_valid, 1'b1);
    #2;
    clr_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    beat_ready = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    tick();
    chk_reset_outputs("midrst_release");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/boot_segment_loader.md
BOOT_SEGMENT_LOADER -- requirements
Module: boot_segment_loader

Interface
REQ-001 Parameter ADDR_W, default 8, width of segment base address.
REQ-002 Parameter LEN_W, default 32, width of segment length in beats.
REQ-003 Parameter DEPTH, default 4, descriptor queue entries; SHALL be a power of two, at least 2.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 clr_n  in  1  reset, asynchronous assert, active-low.
REQ-006 clr  in  1  synchronous soft clear, active-high.
REQ-007 wr_en  in  1  push descriptor {addr_i, len_i}.
REQ-008 addr_i  in  ADDR_W  segment base address.
REQ-009 len_i  in  LEN_W  segment length in beats.
REQ-010 start  in  1  one-cycle pulse to begin draining the queue.
REQ-011 beat_ready  in  1  downstream accepts the current beat.
REQ-012 beat_valid  out  1  beat presented.
REQ-013 beat_addr  out  ADDR_W  base address of the active segment.
REQ-014 beat_idx  out  LEN_W  beat offset within the segment, 0-based.
REQ-015 beat_last  out  1  current beat is the final beat of its segment.
REQ-016 count  out  clog2(DEPTH)+1  queued descriptors.
REQ-017 full, empty  out  1 each  queue status.
REQ-018 busy  out  1  FSM not in IDLE.
REQ-019 done  out  1  one-cycle pulse when the queue has been drained.
REQ-020 ovf  out  1  sticky flag, set by a dropped push.
REQ-021 err  out  1  one-cycle pulse when start arrives in IDLE with the queue empty.

Function
REQ-022 Queue SHALL be a circular FIFO with wrapping read and write pointers; a push when not full SHALL be stored and visible in count on the next cycle.
REQ-023 A push when full with no same-cycle pop SHALL be dropped and SHALL set ovf; a push and pop in the same cycle while full SHALL both succeed.
REQ-024 Pushes SHALL be accepted in every FSM state.
REQ-025 FSM states SHALL be IDLE, LOAD, STREAM and DONE.
REQ-026 IDLE: start with the queue not empty -> LOAD; start with the queue empty -> err pulse and remain in IDLE.
REQ-027 LOAD (one cycle): pop the head into cur_addr/cur_len and clear beat_idx.
REQ-028 From LOAD with len=0, the segment SHALL be skipped: -> LOAD if the queue is still not empty, else -> DONE.
REQ-029 From LOAD with len>0 -> STREAM.
REQ-030 STREAM: beat_valid=1; beat_addr and beat_idx SHALL hold stable until beat_valid&&beat_ready.
REQ-031 On each accepted beat, beat_idx SHALL increment.
REQ-032 beat_last SHALL be 1 exactly when beat_idx == cur_len-1.
REQ-033 On an accepted last beat -> LOAD if the queue is not empty, else -> DONE.
REQ-034 DONE: done=1 for one cycle -> IDLE.
REQ-035 start SHALL be ignored outside IDLE.
REQ-036 Latency: first beat_valid SHALL occur 2 cycles after the start edge (IDLE->LOAD->STREAM).
REQ-037 A len_i of all-ones SHALL stream 2^LEN_W-1 beats; beat_idx SHALL not wrap within a segment.
REQ-038 clr SHALL override all other inputs: flush the queue, clear ovf, drop beat_valid and return to IDLE next cycle with no done pulse; a same-cycle push SHALL be discarded.

Reset
REQ-039 Asserting clr_n low SHALL immediately force IDLE, pointers 0 and count 0, with every output 0 except empty=1.
REQ-040 Deassertion of clr_n SHALL be synchronised externally; the block SHALL take no action on the first edge other than normal operation.

Structure
REQ-041 Package boot_pkg SHALL hold the FSM state enum (boot_state_t) and the descriptor struct type builder constants.
REQ-042 Sub-module boot_desc_fifo (parametrised DEPTH, width ADDR_W+LEN_W) SHALL implement REQ-022/023; the FSM and beat counter SHALL live in the top module.
REQ-043 Estimated size: 150-250 lines of RTL.

Verification
REQ-044 Push (3,400), start, beat_ready=1 -> first beat 2 cycles later; 400 beats with idx 0..399, last at idx 399, then done pulse, busy=0.
REQ-045 Push (1,2),(2,0),(5,1), start -> beats addr1 idx0,1; addr 2 skipped; addr5 idx0 last; single done.
REQ-046 Push 5 descriptors with DEPTH=4 -> full after 4, fifth dropped, ovf=1, count=4; clr -> count=0, ovf=0.
REQ-047 Random beat_ready stalls on a len=5 segment -> addr/idx stable while stalled; exactly 5 handshakes.
REQ-048 start on empty queue -> err pulse, busy stays 0; clr_n asserted mid-STREAM -> all outputs 0 and empty=1 immediately.
REQ-049 Queue full during STREAM, push coincident with LOAD pop -> both succeed, count stays 4, ovf=0.
